matrix_op_sequencer: RTL and testbench

Single-issue controller that accepts 32-bit matrix instructions over a valid/ready handshake, decodes them, and sequences the matrix register file (two read ports, one write port, constant-matrix generator) and the matrix ALU. One instruction is in flight at a time: operand select → ALU start → wait for ALU done → one-cycle write-back. It sits between the instruction source and the data memory / ALU pair, and owns every control input of the data memory.

---
 rtl/matrix_op_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_matrix_op_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_op_sequencer.sv
// matrix_op_sequencer
//   Single-issue controller for the matrix register file and matrix ALU.
//   Accepts one 32-bit instruction at a time over a valid/ready handshake.
//   It drives operand select, then launches the ALU. It waits for the ALU
//   to report done, then strobes a one-cycle write-back.
//
// Ports
//   CLK, RST           clock (rising edge) / asynchronous active-low reset
//   instr_valid/instr  instruction handshake input and instruction word
//   instr_ready        high only while IDLE (registered, depends on state only)
//   read1/read2/write  data-memory port indices
//   generate_enable    data2 taken from the constant-matrix generator
//   constant           immediate for the constant-matrix generator
//   write_enable       one-cycle write strobe to the data memory
//   alu_op/alu_start   ALU operation code and one-cycle launch pulse
//   alu_done           ALU result valid
//   busy/halted/error  status
//   retired_count      retired-instruction counter (wraps)

`ifndef INDEX_BIT
`define INDEX_BIT 4
`endif

module matrix_op_sequencer #(
  parameter int INDEX_BIT = `INDEX_BIT,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     instr_valid,
  input  logic [31:0]              instr,
  output logic                     instr_ready,
  output logic [INDEX_BIT-1:0]     read1,
  output logic [INDEX_BIT-1:0]     read2,
  output logic [INDEX_BIT-1:0]     write,
  output logic                     generate_enable,
  output logic [28-2*INDEX_BIT:0]  constant,
  output logic                     write_enable,
  output logic [2:0]               alu_op,
  output logic                     alu_start,
  input  logic                     alu_done,
  output logic                     busy,
  output logic                     halted,
  output logic                     error,
  output logic [CNT_W-1:0]         retired_count
);

  localparam int CONST_W = 29 - 2*INDEX_BIT;
  localparam int TMR_W   = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_MULI = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  // Instruction fields; src2 deliberately overlaps the top of imm.
  logic [2:0]           f_op;
  logic [INDEX_BIT-1:0] f_dst;
  logic [INDEX_BIT-1:0] f_src1;
  logic [INDEX_BIT-1:0] f_src2;
  logic [CONST_W-1:0]   f_imm;

  assign f_op   = instr[31:29];
  assign f_dst  = instr[28 -: INDEX_BIT];
  assign f_src1 = instr[28-INDEX_BIT -: INDEX_BIT];
  assign f_src2 = instr[28-2*INDEX_BIT -: INDEX_BIT];
  assign f_imm  = instr[CONST_W-1:0];

  state_t               state_q,   state_d;
  logic [TMR_W-1:0]     tmr_q,     tmr_d;
  logic [INDEX_BIT-1:0] read1_q,   read1_d;
  logic [INDEX_BIT-1:0] read2_q,   read2_d;
  logic [INDEX_BIT-1:0] write_q,   write_d;
  logic                 gen_q,     gen_d;
  logic [CONST_W-1:0]   const_q,   const_d;
  logic [2:0]           alu_op_q,  alu_op_d;
  logic                 start_q,   start_d;
  logic                 we_q,      we_d;
  logic                 ready_q,   ready_d;
  logic                 busy_q,    busy_d;
  logic                 halted_q,  halted_d;
  logic                 error_q,   error_d;
  logic [CNT_W-1:0]     retired_q, retired_d;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    read1_d   = read1_q;
    read2_d   = read2_q;
    write_d   = write_q;
    gen_d     = gen_q;
    const_d   = const_q;
    alu_op_d  = alu_op_q;
    retired_d = retired_q;

    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          if (f_op == OP_NOP) begin
            retired_d = retired_q + CNT_W'(1);
          end else if (f_op == OP_HALT) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_HALT;
          end else begin
            // Operands are latched at accept so they are already valid in ISSUE.
            read1_d  = f_src1;
            read2_d  = f_src2;
            write_d  = f_dst;
            alu_op_d = f_op;
            gen_d    = (f_op == OP_ADDI) || (f_op == OP_MULI);
            const_d  = ((f_op == OP_ADDI) || (f_op == OP_MULI)) ? f_imm : '0;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done takes priority over a timeout reached in the same cycle.
        if (alu_done) begin
          state_d = S_WB;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_WB: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    // Outputs are registered from the next state so they line up with it.
    start_d  = (state_d == S_ISSUE);
    we_d     = (state_d == S_WB);
    ready_d  = (state_d == S_IDLE);
    busy_d   = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_WB);
    halted_d = (state_d == S_HALT);
    error_d  = (state_d == S_ERR);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      read1_q   <= '0;
      read2_q   <= '0;
      write_q   <= '0;
      gen_q     <= 1'b0;
      const_q   <= '0;
      alu_op_q  <= '0;
      start_q   <= 1'b0;
      we_q      <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      error_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      read1_q   <= read1_d;
      read2_q   <= read2_d;
      write_q   <= write_d;
      gen_q     <= gen_d;
      const_q   <= const_d;
      alu_op_q  <= alu_op_d;
      start_q   <= start_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      error_q   <= error_d;
      retired_q <= retired_d;
    end
  end

  assign instr_ready     = ready_q;
  assign read1           = read1_q;
  assign read2           = read2_q;
  assign write           = write_q;
  assign generate_enable = gen_q;
  assign constant        = const_q;
  assign write_enable    = we_q;
  assign alu_op          = alu_op_q;
  assign alu_start       = start_q;
  assign busy            = busy_q;
  assign halted          = halted_q;
  assign error           = error_q;
  assign retired_count   = retired_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
module tb_matrix_op_sequencer;

  localparam int IB = 4;
  localparam int CW = 29 - 2*IB;

  logic          CLK;
  logic          RST;
  logic          instr_valid;
  logic [31:0]   instr;
  logic          instr_ready;
  logic [IB-1:0] read1, read2, write;
  logic          generate_enable;
  logic [CW-1:0] constant;
  logic          write_enable;
  logic [2:0]    alu_op;
  logic          alu_start;
  logic          alu_done;
  logic          busy, halted, error;
  logic [15:0]   retired_count;

  matrix_op_sequencer #(.INDEX_BIT(IB), .TIMEOUT(8), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .read1(read1), .read2(read2), .write(write),
    .generate_enable(generate_enable), .constant(constant),
    .write_enable(write_enable), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .busy(busy), .halted(halted), .error(error),
    .retired_count(retired_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  int we_cnt = 0;
  int st_cnt = 0;
  int we0, st0;

  // Pulse counters sampled away from the active edge.
  always @(negedge CLK) begin
    if (write_enable === 1'b1) we_cnt++;
    if (alu_start === 1'b1)    st_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    alu_done = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  // Present one instruction for a single accept edge; returns in the ISSUE cycle.
  task automatic issue(input logic [31:0] w);
    instr_valid = 1'b1;
    instr = w;
    step();
    instr_valid = 1'b0;
    instr = '0;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, s2, 17'd0};
  endfunction

  initial begin
    RST = 1'b0; instr_valid = 1'b0; instr = '0; alu_done = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready",   32'(instr_ready),   32'd1);
    chk("rst_busy",    32'(busy),          32'd0);
    chk("rst_retired", 32'(retired_count), 32'd0);
    chk("rst_we",      32'(write_enable),  32'd0);
    chk("rst_start",   32'(alu_start),     32'd0);
    chk("rst_halted",  32'(halted),        32'd0);
    chk("rst_error",   32'(error),         32'd0);
    chk("rst_write",   32'(write),         32'd0);
    chk("rst_gen",     32'(generate_enable), 32'd0);
    RST = 1'b1;

    // ADD dst=2 src1=0 src2=1, done three cycles after alu_start
    st0 = st_cnt; we0 = we_cnt;
    issue(mk(3'b001, 4'd2, 4'd0, 4'd1));
    chk("add_start",  32'(alu_start),   32'd1);
    chk("add_read1",  32'(read1),       32'd0);
    chk("add_read2",  32'(read2),       32'd1);
    chk("add_write",  32'(write),       32'd2);
    chk("add_op",     32'(alu_op),      32'd1);
    chk("add_ready",  32'(instr_ready), 32'd0);
    chk("add_busy",   32'(busy),        32'd1);
    step();
    chk("add_start_off", 32'(alu_start), 32'd0);
    step();
    step();
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    chk("add_wb_we",      32'(write_enable),  32'd1);
    chk("add_wb_write",   32'(write),         32'd2);
    chk("add_wb_read1",   32'(read1),         32'd0);
    chk("add_wb_read2",   32'(read2),         32'd1);
    chk("add_wb_retired", 32'(retired_count), 32'd0);
    step();
    chk("add_idle_we",      32'(write_enable),  32'd0);
    chk("add_idle_retired", 32'(retired_count), 32'd1);
    chk("add_idle_ready",   32'(instr_ready),   32'd1);
    chk("add_idle_busy",    32'(busy),          32'd0);
    chk("add_start_pulses", 32'(st_cnt - st0),  32'd1);
    chk("add_we_pulses",    32'(we_cnt - we0),  32'd1);

    // ADDI dst=1 src1=1 imm=5, done in the first WAIT cycle
    we0 = we_cnt;
    issue({3'b100, 4'd1, 4'd1, 21'd5});
    chk("addi_gen",   32'(generate_enable), 32'd1);
    chk("addi_const", 32'(constant),        32'd5);
    chk("addi_op",    32'(alu_op),          32'd4);
    chk("addi_read1", 32'(read1),           32'd1);
    step();
    chk("addi_wait_gen",   32'(generate_enable), 32'd1);
    chk("addi_wait_const", 32'(constant),        32'd5);
    chk("addi_wait_write", 32'(write),           32'd1);
    chk("addi_wait_we",    32'(write_enable),    32'd0);
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    chk("addi_wb_we",    32'(write_enable), 32'd1);
    chk("addi_wb_write", 32'(write),        32'd1);
    step();
    chk("addi_idle_we",  32'(write_enable),  32'd0);
    chk("addi_retired",  32'(retired_count), 32'd2);
    chk("addi_we_pulses", 32'(we_cnt - we0), 32'd1);

    // Four back-to-back NOPs
    do_reset();
    st0 = st_cnt;
    instr_valid = 1'b1;
    instr = 32'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("nop_retired", 32'(retired_count), 32'(i + 1));
      chk("nop_ready",   32'(instr_ready),   32'd1);
    end
    instr_valid = 1'b0;
    step();
    chk("nop_final",  32'(retired_count), 32'd4);
    chk("nop_starts", 32'(st_cnt - st0),  32'd0);

    // MUL with no done: timeout after 8 WAIT cycles
    do_reset();
    we0 = we_cnt;
    issue(mk(3'b011, 4'd3, 4'd1, 4'd2));
    chk("mul_op", 32'(alu_op), 32'd3);
    for (int i = 1; i <= 8; i++) step();
    chk("to_wait8_error", 32'(error), 32'd0);
    chk("to_wait8_busy",  32'(busy),  32'd1);
    step();
    chk("to_error", 32'(error),       32'd1);
    chk("to_ready", 32'(instr_ready), 32'd0);
    chk("to_busy",  32'(busy),        32'd0);
    instr_valid = 1'b1;
    instr = mk(3'b001, 4'd2, 4'd0, 4'd1);
    alu_done = 1'b1;
    repeat (3) step();
    instr_valid = 1'b0;
    alu_done = 1'b0;
    chk("to_hold_error", 32'(error),         32'd1);
    chk("to_hold_ready", 32'(instr_ready),   32'd0);
    chk("to_retired",    32'(retired_count), 32'd0);
    chk("to_no_we",      32'(we_cnt - we0),  32'd0);

    // Done in the same cycle the timeout is reached: done wins
    do_reset();
    issue(mk(3'b010, 4'd5, 4'd5, 4'd6));
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 8) alu_done = 1'b1;
    end
    step();
    alu_done = 1'b0;
    chk("edge_we",    32'(write_enable), 32'd1);
    chk("edge_error", 32'(error),        32'd0);
    chk("edge_write", 32'(write),        32'd5);
    step();
    chk("edge_retired", 32'(retired_count), 32'd1);
    chk("edge_ready",   32'(instr_ready),   32'd1);

    // MOV then HALT
    do_reset();
    issue(mk(3'b110, 4'd2, 4'd3, 4'd0));
    step();
    alu_done = 1'b1;
    step();
    alu_done = 1'b0;
    step();
    chk("mov_retired", 32'(retired_count), 32'd1);
    instr_valid = 1'b1;
    instr = {3'b111, 29'd0};
    step();
    chk("halt_halted",  32'(halted),        32'd1);
    chk("halt_ready",   32'(instr_ready),   32'd0);
    chk("halt_retired", 32'(retired_count), 32'd2);
    chk("halt_busy",    32'(busy),          32'd0);
    st0 = st_cnt;
    instr = mk(3'b001, 4'd2, 4'd0, 4'd1);
    repeat (3) step();
    instr_valid = 1'b0;
    chk("halt_hold",         32'(halted),        32'd1);
    chk("halt_hold_retired", 32'(retired_count), 32'd2);
    chk("halt_no_start",     32'(st_cnt - st0),  32'd0);

    // Reset dropped mid-WAIT aborts the instruction
    do_reset();
    issue(mk(3'b001, 4'd2, 4'd0, 4'd1));
    step();
    step();
    we0 = we_cnt;
    RST = 1'b0;
    #1;
    chk("abort_busy",  32'(busy),        32'd0);
    chk("abort_ready", 32'(instr_ready), 32'd1);
    step();
    RST = 1'b1;
    alu_done = 1'b1;
    step();
    step();
    alu_done = 1'b0;
    chk("abort_no_we",   32'(we_cnt - we0),  32'd0);
    chk("abort_retired", 32'(retired_count), 32'd0);
    chk("abort_idle",    32'(instr_ready),   32'd1);
    chk("abort_notbusy", 32'(busy),          32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
